fp_pipe_arbiter: RTL

- Round-robin arbiter that shares one fixed-latency floating-point pipeline between four requesters. The pipeline is a chain of register stages carrying 24-bit mantissas A/B, 8-bit exponents AE/BE, signs AS/BS and an 8-bit tag D.
- Grants one operand set per cycle and drives the pipeline input.
- Tracks in-flight operations with a valid/ID shift register so each result leaving the pipeline is steered back to its owner.
- Sits between the radix-5 butterfly sequencers and the shared FP add/sub pipeline.

---
 rtl/fp_pipe_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/fp_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP pipeline between four requesters.
// A LAT-deep valid/tag shift register steers each emerging result back to its owner.
module fp_pipe_arbiter #(
    parameter int unsigned LAT = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  EN,
    input  logic [3:0]  REQ,
    input  logic [95:0] RA,
    input  logic [95:0] RB,
    input  logic [31:0] RAE,
    input  logic [31:0] RBE,
    input  logic [3:0]  RAS,
    input  logic [3:0]  RBS,
    input  logic [23:0] RTAG,
    output logic [3:0]  GNT,
    output logic [23:0] PA,
    output logic [23:0] PB,
    output logic [7:0]  PAE,
    output logic [7:0]  PBE,
    output logic        PAS,
    output logic        PBS,
    output logic [7:0]  PD,
    output logic        PV,
    output logic        DONE_V,
    output logic [1:0]  DONE_ID,
    output logic [5:0]  DONE_TAG,
    output logic        IDLE,
    output logic [15:0] ISSUE_CNT
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned MW   = 24;
    localparam int unsigned EW   = 8;
    localparam int unsigned TW   = 6;
    localparam int unsigned DW   = IDW + TW;

    logic [IDW-1:0]  r_ptr;
    logic [LAT-1:0]  r_trk_v;
    logic [DW-1:0]   r_trk_d [LAT];

    logic [NREQ-1:0] w_elig;
    logic            w_any;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;

    // Search from the pointer upward; iterating backwards lets the nearest eligible win.
    always_comb begin
        w_elig = REQ & EN & ~GNT;
        w_any  = 1'b0;
        w_win  = r_ptr;
        w_idx  = r_ptr;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_idx = r_ptr + IDW'(k);
            if (w_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT       <= '0;
            PA        <= '0;
            PB        <= '0;
            PAE       <= '0;
            PBE       <= '0;
            PAS       <= 1'b0;
            PBS       <= 1'b0;
            PD        <= '0;
            PV        <= 1'b0;
            ISSUE_CNT <= '0;
            r_ptr     <= '0;
            r_trk_v   <= '0;
            for (int s = 0; s < int'(LAT); s++) begin
                r_trk_d[s] <= '0;
            end
        end else begin
            GNT <= '0;
            PV  <= 1'b0;
            if (w_any) begin
                GNT       <= NREQ'(1) << w_win;
                PA        <= RA[int'(w_win)*MW +: MW];
                PB        <= RB[int'(w_win)*MW +: MW];
                PAE       <= RAE[int'(w_win)*EW +: EW];
                PBE       <= RBE[int'(w_win)*EW +: EW];
                PAS       <= RAS[w_win];
                PBS       <= RBS[w_win];
                PD        <= {w_win, RTAG[int'(w_win)*TW +: TW]};
                PV        <= 1'b1;
                r_ptr     <= w_win + IDW'(1);
                ISSUE_CNT <= ISSUE_CNT + 16'd1;
            end
            // Tracking mirrors the pipeline: one stage per cycle, no stalls.
            r_trk_v[0] <= PV;
            r_trk_d[0] <= PD;
            for (int s = 1; s < int'(LAT); s++) begin
                r_trk_v[s] <= r_trk_v[s-1];
                r_trk_d[s] <= r_trk_d[s-1];
            end
        end
    end

    assign DONE_V   = r_trk_v[LAT-1];
    assign DONE_ID  = r_trk_d[LAT-1][DW-1:TW];
    assign DONE_TAG = r_trk_d[LAT-1][TW-1:0];
    assign IDLE     = ~PV & ~(|r_trk_v);

endmodule
